// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, FSM states and
// datapath select encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StTrap   = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control unit (master) and the instruction register / datapath (slave).
interface multicycle_control_if;
  logic [5:0] opcode_in;
  logic       mem_ready_in;
  logic       pcWrite_out;
  logic       pcWriteCond_out;
  logic       iorD_out;
  logic       memRead_out;
  logic       memWrite_out;
  logic       memtoReg_out;
  logic       irWrite_out;
  logic       aluSrcA_out;
  logic       regWrite_out;
  logic       regDst_out;
  logic [1:0] aluOp_out;
  logic [1:0] aluSrcB_out;
  logic [1:0] pcSource_out;
  logic [3:0] state_out;
  logic       illegal_out;
  logic       fault_out;

  modport master (
    input  opcode_in, mem_ready_in,
    output pcWrite_out, pcWriteCond_out, iorD_out, memRead_out, memWrite_out, memtoReg_out,
           irWrite_out, aluSrcA_out, regWrite_out, regDst_out, aluOp_out, aluSrcB_out,
           pcSource_out, state_out, illegal_out, fault_out
  );

  modport slave (
    output opcode_in, mem_ready_in,
    input  pcWrite_out, pcWriteCond_out, iorD_out, memRead_out, memWrite_out, memtoReg_out,
           irWrite_out, aluSrcA_out, regWrite_out, regDst_out, aluOp_out, aluSrcB_out,
           pcSource_out, state_out, illegal_out, fault_out
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state; expire flags the cycle that would
// push the wait past MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic clear,
  input  logic count,
  input  logic ready,
  output logic expire
);
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && !ready) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A same-cycle ready always beats the timeout.
  assign expire = count && !ready && (cnt_q == CntW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait timeout and illegal-opcode trapping.
// Define ADDI_EN to enable the addi path (ADDIEX -> ADDIWB); otherwise opcode 001000 traps.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  multicycle_control_if.master bus
);

  state_t state_q, state_d;
  logic   is_load_q;
  logic   illegal_q, fault_q;
  logic   set_illegal, set_fault;
  logic   timer_count, timer_expire;

  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, memto_reg, ir_write;
  logic       alu_src_a, reg_write, reg_dst;
  logic [1:0] alu_op, alu_src_b, pc_source;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .clear     (state_d != state_q),
    .count     (timer_count),
    .ready     (bus.mem_ready_in),
    .expire    (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    timer_count = 1'b0;
    unique case (state_q)
      StFetch, StMemRd, StMemWr: begin
        timer_count = 1'b1;
        if (bus.mem_ready_in) begin
          unique case (state_q)
            StFetch: state_d = StDecode;
            StMemRd: state_d = StMemWb;
            default: state_d = StFetch;
          endcase
        end else if (timer_expire) begin
          state_d   = StTrap;
          set_fault = 1'b1;
        end
      end
      StDecode: begin
        unique case (bus.opcode_in)
          OP_RTYPE:     state_d = StExec;
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
`ifdef ADDI_EN
          OP_ADDI:      state_d = StAddiEx;
`endif
          default: begin
            state_d     = StTrap;
            set_illegal = 1'b1;
          end
        endcase
      end
      // opcode_in is not stable here, so use the load/store choice captured in DECODE.
      StMemAdr: state_d = is_load_q ? StMemRd : StMemWr;
      StExec:   state_d = StAluWb;
      StMemWb, StAluWb, StBranch, StJump: state_d = StFetch;
`ifdef ADDI_EN
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
`endif
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q   <= StFetch;
      is_load_q <= 1'b0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | set_illegal;
      fault_q   <= fault_q | set_fault;
      if (state_q == StDecode) begin
        is_load_q <= (bus.opcode_in == OP_LW);
      end
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    memto_reg     = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_op        = ALUOP_ADD;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_source = PCSRC_ALU;
        ir_write  = bus.mem_ready_in;
        pc_write  = bus.mem_ready_in;
      end
      StDecode: alu_src_b = SRCB_IMM_SHL2;
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      StMemRd: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
      end
      StMemWb: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      StAddiWb: reg_write = 1'b1;
      default: ;
    endcase
    // Reset aborts mid-instruction: no write of any kind may leak out while it is held.
    if (!reset_n_in) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
    end
  end

  assign bus.pcWrite_out     = pc_write;
  assign bus.pcWriteCond_out = pc_write_cond;
  assign bus.iorD_out        = ior_d;
  assign bus.memRead_out     = mem_read;
  assign bus.memWrite_out    = mem_write;
  assign bus.memtoReg_out    = memto_reg;
  assign bus.irWrite_out     = ir_write;
  assign bus.aluSrcA_out     = alu_src_a;
  assign bus.regWrite_out    = reg_write;
  assign bus.regDst_out      = reg_dst;
  assign bus.aluOp_out       = alu_op;
  assign bus.aluSrcB_out     = alu_src_b;
  assign bus.pcSource_out    = pc_source;
  assign bus.state_out       = state_q;
  assign bus.illegal_out     = illegal_q;
  assign bus.fault_out       = fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle states and control values.
module tb_multicycle_control;

  localparam int unsigned TO = 4;
  localparam logic [15:0] EN_MASK = 16'hDA80;

  logic clk_in = 1'b0;
  logic reset_n_in = 1'b0;

  multicycle_control_if bus ();

  multicycle_control #(
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .bus       (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic [5:0] op;
    logic       ill;
    logic       flt;
  } cyc_t;

  cyc_t q[$];
  logic m_ill = 1'b0;
  logic m_flt = 1'b0;
  logic m_trap = 1'b0;

  // {pcWrite,pcWriteCond,iorD,memRead,memWrite,memtoReg,irWrite,aluSrcA,regWrite,regDst,
  //  aluOp[1:0],aluSrcB[1:0],pcSource[1:0]}
  function automatic logic [15:0] exp_out(input logic [3:0] st, input logic rdy);
    logic pcw, pcc, iord, mrd, mwr, m2r, irw, sa, rw, rd;
    logic [1:0] aop, sb, ps;
    {pcw, pcc, iord, mrd, mwr, m2r, irw, sa, rw, rd} = '0;
    aop = 2'b00; sb = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  sb = 2'b11;
      4'd2, 4'd10: begin sa = 1; sb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pcc = 1; ps = 2'b01; end
      4'd9:  begin pcw = 1; ps = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pcw, pcc, iord, mrd, mwr, m2r, irw, sa, rw, rd, aop, sb, ps};
  endfunction

  function automatic logic [15:0] act_out();
    return {bus.pcWrite_out, bus.pcWriteCond_out, bus.iorD_out, bus.memRead_out,
            bus.memWrite_out, bus.memtoReg_out, bus.irWrite_out, bus.aluSrcA_out,
            bus.regWrite_out, bus.regDst_out, bus.aluOp_out, bus.aluSrcB_out,
            bus.pcSource_out};
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.op = op; c.ill = m_ill; c.flt = m_flt;
    q.push_back(c);
  endtask

  task automatic push_trap();
    for (int k = 0; k < 3; k++) push(4'd12, rbit(), rop());
    m_trap = 1'b1;
  endtask

  // Memory access: `waits` not-ready cycles, then ready, unless the wait times out.
  task automatic mem_phase(input logic [3:0] st, input int waits);
    for (int k = 0; k < waits && k < TO; k++) push(st, 1'b0, rop());
    if (waits >= TO) begin
      m_flt = 1'b1;
      push_trap();
    end else begin
      push(st, 1'b1, rop());
    end
  endtask

  task automatic build(input logic [5:0] op, input int fw, input int mw);
    m_trap = 1'b0;
    mem_phase(4'd0, fw);
    if (m_trap) return;
    push(4'd1, rbit(), op);
    case (op)
      6'b000000: begin push(4'd6, rbit(), rop()); push(4'd7, rbit(), rop()); end
      6'b100011: begin
        push(4'd2, rbit(), rop());
        mem_phase(4'd3, mw);
        if (!m_trap) push(4'd4, rbit(), rop());
      end
      6'b101011: begin push(4'd2, rbit(), rop()); mem_phase(4'd5, mw); end
      6'b000100: push(4'd8, rbit(), rop());
      6'b000010: push(4'd9, rbit(), rop());
`ifdef ADDI_EN
      6'b001000: begin push(4'd10, rbit(), rop()); push(4'd11, rbit(), rop()); end
`endif
      default: begin m_ill = 1'b1; push_trap(); end
    endcase
  endtask

  // Entered at posedge+1; each cycle drives inputs, samples, then moves to the next posedge+1.
  task automatic play();
    cyc_t c;
    logic [15:0] e, a;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.mem_ready_in = c.rdy;
      bus.opcode_in = c.op;
      #1;
      checks++;
      if (bus.state_out !== c.st) begin
        errors++;
        $display("FAIL state @%0t: got %0d expected %0d", $time, bus.state_out, c.st);
      end
      e = exp_out(c.st, c.rdy);
      a = act_out();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL controls @%0t (state %0d): got %h expected %h", $time, c.st, a, e);
      end
      checks++;
      if ({bus.illegal_out, bus.fault_out} !== {c.ill, c.flt}) begin
        errors++;
        $display("FAIL flags @%0t: got ill=%b flt=%b expected ill=%b flt=%b", $time,
                 bus.illegal_out, bus.fault_out, c.ill, c.flt);
      end
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] cur_st);
    reset_n_in = 1'b0;
    bus.mem_ready_in = 1'b1;
    bus.opcode_in = rop();
    #1;
    checks++;
    if (bus.state_out !== cur_st) begin
      errors++;
      $display("FAIL reset_pre_state: got %0d expected %0d", bus.state_out, cur_st);
    end
    checks++;
    if ((act_out() & EN_MASK) !== 16'h0) begin
      errors++;
      $display("FAIL reset_enables: got %h expected 0000", act_out() & EN_MASK);
    end
    @(posedge clk_in);
    #1;
    checks++;
    if ({bus.state_out, bus.illegal_out, bus.fault_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_post: got state=%0d ill=%b flt=%b expected 0 0 0",
               bus.state_out, bus.illegal_out, bus.fault_out);
    end
    reset_n_in = 1'b1;
    m_ill = 1'b0;
    m_flt = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_in = 1'b0;
    bus.mem_ready_in = 1'b1;
    bus.opcode_in = 6'b0;
    #1;
    checks++;
    if ((act_out() & EN_MASK) !== 16'h0) begin
      errors++;
      $display("FAIL reset_enables_initial: got %h expected 0000", act_out() & EN_MASK);
    end
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    checks++;
    if ({bus.state_out, bus.illegal_out, bus.fault_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_initial: got state=%0d ill=%b flt=%b expected 0 0 0",
               bus.state_out, bus.illegal_out, bus.fault_out);
    end
    reset_n_in = 1'b1;
  endtask

  task automatic test_rtype();
    build(6'b000000, 0, 0);
    play();
  endtask

  task automatic test_lw_wait();
    build(6'b100011, 0, 3);
    play();
    build(6'b101011, 1, 2);
    play();
  endtask

  task automatic test_beq_j();
    build(6'b000100, 0, 0);
    play();
    build(6'b000010, 2, 0);
    play();
  endtask

  task automatic test_illegal();
    build(6'b111111, 0, 0);
    play();
    do_reset(4'd12);
  endtask

  task automatic test_timeout();
    build(6'b000000, 4, 0);
    play();
    do_reset(4'd12);
    build(6'b000000, 3, 0);
    play();
    build(6'b100011, 0, 4);
    play();
    do_reset(4'd12);
  endtask

  task automatic test_addi();
    build(6'b001000, 0, 0);
    play();
    if (m_trap) do_reset(4'd12);
  endtask

  task automatic test_reset_mid();
    push(4'd0, 1'b1, rop());
    push(4'd1, rbit(), 6'b000000);
    push(4'd6, rbit(), rop());
    play();
    do_reset(4'd7);
    do_reset(4'd0);
  endtask

  task automatic test_random();
    logic [5:0] ops[8];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000,
            6'b111111, 6'b000000};
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      int fw, mw;
      op = ($urandom_range(0, 9) == 0) ? rop() : ops[$urandom_range(0, 7)];
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 3));
      build(op, fw, mw);
      play();
      if (m_trap) do_reset(4'd12);
    end
  endtask

  initial begin
    bus.mem_ready_in = 1'b0;
    bus.opcode_in = 6'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq_j();
    test_illegal();
    test_timeout();
    test_addi();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
